rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter LOAD_INDEX, default 8'h00, ioctl_index value selecting ROM download.
REQ-003 clk_sys  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ioctl_download  input  1  download in progress.
REQ-006 ioctl_index  input  8  download target index.
REQ-007 ioctl_wr  input  1  one-cycle pulse: ioctl_addr/ioctl_dout valid.
REQ-008 ioctl_addr  input  25  byte address within the download image.
REQ-009 ioctl_dout  input  8  data byte.
REQ-010 mem_wr  output  1  SDRAM write request, held until mem_ack.
REQ-011 mem_addr  output  23  SDRAM byte address.
REQ-012 mem_bank  output  2  SDRAM bank.
REQ-013 mem_din  output  8  SDRAM write data.
REQ-014 mem_ack  input  1  one-cycle pulse: the SDRAM controller has accepted the current request.
REQ-015 cpu_reset  output  1  holds the CPU/motherboard in reset while loading or draining.
REQ-016 done  output  1  one-cycle pulse when a load completes and the FIFO is empty.
REQ-017 overflow  output  1  sticky flag: a byte was lost because the FIFO was full.
REQ-018 dropped  output  1  sticky flag: a byte was discarded because its address fell outside the map.

Function
REQ-019 Active load SHALL be ioctl_download=1 and ioctl_index=LOAD_INDEX; other indices SHALL be ignored entirely.
REQ-020 Segment seg=ioctl_addr[24:14]; mem_addr[13:0]=ioctl_addr[13:0]; mem_addr[22:14] SHALL be: seg 0,4 -> 9'h000; 1,5 -> 9'h100; 2,6 -> 9'h107; 3,7 -> 9'h1FF.
REQ-021 mem_bank SHALL be {1'b0, seg[2]}.
REQ-022 seg>=8 SHALL NOT be enqueued; it SHALL set dropped.
REQ-023 Each accepted ioctl_wr SHALL push {bank, addr, data} (33 bits) into the FIFO in the same cycle.
REQ-024 FIFO full and an accepted ioctl_wr SHALL discard the byte and set overflow; FIFO contents SHALL be unaffected.
REQ-025 Head entry SHALL drive mem_addr/mem_bank/mem_din; mem_wr=1 whenever the FIFO is non-empty; outputs SHALL remain stable until mem_ack.
REQ-026 mem_ack with mem_wr=1 SHALL pop the head; the next entry SHALL be presented on the following cycle.
REQ-027 mem_ack with mem_wr=0 SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL both take effect, and the occupancy SHALL be unchanged; push while full and popping in the same cycle SHALL be accepted (no overflow).
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-030 FSM states: IDLE, LOAD, DRAIN, DONE.
REQ-031 IDLE -> LOAD when active load rises; clears overflow and dropped on entry.
REQ-032 LOAD -> DRAIN when ioctl_download falls.
REQ-033 DRAIN -> DONE when the FIFO is empty; DONE lasts exactly one cycle, asserts done, then -> IDLE.
REQ-034 DRAIN or DONE with a new active-load rise SHALL go to LOAD without clearing the FIFO.
REQ-035 cpu_reset SHALL be 1 in LOAD and DRAIN, and 0 in IDLE and DONE.
REQ-036 Latency: ioctl_wr into an empty FIFO SHALL raise mem_wr on the next clock edge.

Reset
REQ-037 reset=1 SHALL immediately force: state IDLE, FIFO empty, mem_wr=0, mem_addr=0, mem_bank=0, mem_din=0, cpu_reset=0, done=0, overflow=0, dropped=0.
REQ-038 Reset mid-load SHALL discard all queued bytes; no mem_wr SHALL be issued until a new ioctl_wr is accepted after reset release.

Verification
REQ-039 Write 0x3E at ioctl_addr 0x0_4005 (seg 1) -> mem_addr=0x400005, mem_bank=0, mem_din=0x3E, mem_wr held until mem_ack.
REQ-040 Write at ioctl_addr 0x1_C000 (seg 7) -> mem_addr=0x7FC000, mem_bank=1; write at 0x2_0000 (seg 8) -> no mem_wr, dropped=1.
REQ-041 DEPTH=4, mem_ack held 0, five ioctl_wr -> four queued, overflow=1; then four mem_ack pulses -> first four bytes written in order.
REQ-042 ioctl_download falls with 3 entries queued -> cpu_reset stays 1 through DRAIN; done pulses 1 cycle after the third mem_ack; cpu_reset=0 in that same cycle.
REQ-043 Assert reset asynchronously with 2 entries queued -> mem_wr=0 and cpu_reset=0 before the next clock edge; no writes after release.
REQ-044 ioctl_index=1 with ioctl_wr pulses -> no mem_wr, cpu_reset stays 0.

Source files
------------

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Turns ioctl ROM download bytes into SDRAM write requests through
//               a small FIFO, and holds the CPU in reset until all bytes are written.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] LOAD_INDEX = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        mem_wr,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic        cpu_reset,
    output logic        done,
    output logic        overflow,
    output logic        dropped
);

    localparam int             c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]  c_depth = DEPTH[c_aw:0];

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_active_d;
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_aw:0]   r_count;
    logic [c_aw:0]   w_count_next;
    logic            r_overflow;
    logic            r_dropped;
    logic [32:0]     r_fifo [DEPTH];

    logic            w_active;
    logic            w_rise;
    logic            w_accept;
    logic            w_in_map;
    logic [8:0]      w_hi;
    logic [32:0]     w_entry;
    logic [32:0]     w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf;
    logic            w_drop;

    assign w_active = ioctl_download && (ioctl_index == LOAD_INDEX);
    assign w_rise   = w_active && !r_active_d;
    assign w_accept = ioctl_wr && w_active;
    // Segments 0..7 only: anything at or above 128 KiB is outside the map.
    assign w_in_map = (ioctl_addr[24:17] == 8'h00);

    always_comb begin
        w_hi = 9'h000;
        case (ioctl_addr[15:14])
            2'd0:    w_hi = 9'h000;
            2'd1:    w_hi = 9'h100;
            2'd2:    w_hi = 9'h107;
            default: w_hi = 9'h1FF;
        endcase
    end

    assign w_entry = {1'b0, ioctl_addr[16], w_hi, ioctl_addr[13:0], ioctl_dout};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = mem_ack && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = w_accept && w_in_map && (!w_full || w_pop);
    assign w_ovf   = w_accept && w_in_map && w_full && !w_pop;
    assign w_drop  = w_accept && !w_in_map;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_rise) w_state_next = c_st_load;
            c_st_load:  if (!ioctl_download) w_state_next = c_st_drain;
            c_st_drain: begin
                if (w_rise) begin
                    w_state_next = c_st_load;
                end else if (w_count_next == '0) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done:  w_state_next = w_rise ? c_st_load : c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_active_d <= 1'b0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_active_d <= w_active;
            if (r_state == c_st_idle && w_rise) begin
                r_overflow <= 1'b0;
                r_dropped  <= 1'b0;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // Head fields are gated so an empty FIFO always presents zeros.
    assign w_head    = r_fifo[r_rptr];
    assign mem_wr    = !w_empty;
    assign mem_bank  = w_empty ? 2'b00  : w_head[32:31];
    assign mem_addr  = w_empty ? 23'h0  : w_head[30:8];
    assign mem_din   = w_empty ? 8'h00  : w_head[7:0];
    assign cpu_reset = (r_state == c_st_load) || (r_state == c_st_drain);
    assign done      = (r_state == c_st_done);
    assign overflow  = r_overflow;
    assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Scoreboard bench for rom_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    localparam int         DEPTH      = 4;
    localparam logic [7:0] LOAD_INDEX = 8'h00;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        mem_wr;
    logic [22:0] mem_addr;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_din;
    logic        mem_ack;
    logic        cpu_reset;
    logic        done;
    logic        overflow;
    logic        dropped;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [32:0] sb [$];

    rom_loader #(.DEPTH(DEPTH), .LOAD_INDEX(LOAD_INDEX)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_bank       (mem_bank),
        .mem_din        (mem_din),
        .mem_ack        (mem_ack),
        .cpu_reset      (cpu_reset),
        .done           (done),
        .overflow       (overflow),
        .dropped        (dropped)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] exp_entry(input logic [24:0] a, input logic [7:0] d);
        logic [8:0] hi;
        case (a[15:14])
            2'd0:    hi = 9'h000;
            2'd1:    hi = 9'h100;
            2'd2:    hi = 9'h107;
            default: hi = 9'h1FF;
        endcase
        return {1'b0, a[16], hi, a[13:0], d};
    endfunction

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        if (a[24:17] == 8'h00 && sb.size() < DEPTH) sb.push_back(exp_entry(a, d));
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack_one(input string name);
        int          n = 0;
        logic [32:0] exp;
        while (mem_wr !== 1'b1 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        tests_run++;
        if (mem_wr !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: mem_wr=%0b queued=%0d, required mem_wr=1 with an expected entry", name, mem_wr, sb.size());
        end else begin
            exp = sb.pop_front();
            tests_run++;
            if ({mem_bank, mem_addr, mem_din} !== exp) begin
                tests_failed++;
                $display("FAIL %s: bank/addr/din=%h/%h/%h required %h/%h/%h", name,
                         mem_bank, mem_addr, mem_din, exp[32:31], exp[30:8], exp[7:0]);
            end
        end
        mem_ack = 1'b1;
        @(negedge clk_sys);
        mem_ack = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk_sys);
        ioctl_index    = LOAD_INDEX;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        tests_run++;
        if ({mem_wr, mem_addr, mem_bank, mem_din, cpu_reset, done, overflow, dropped} !== 38'h0) begin
            tests_failed++;
            $display("FAIL reset_state: wr=%0b addr=%h bank=%0d din=%h cpu_reset=%0b done=%0b ovf=%0b drop=%0b required all 0",
                     mem_wr, mem_addr, mem_bank, mem_din, cpu_reset, done, overflow, dropped);
        end
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        start_load();
        tests_run++;
        if (cpu_reset !== 1'b1 || mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_entry: cpu_reset=%0b mem_wr=%0b required 1/0", cpu_reset, mem_wr);
        end
        wr_byte(25'h0_4005, 8'h3E);
        tests_run++;
        if (mem_wr !== 1'b1 || mem_addr !== 23'h400005 || mem_bank !== 2'd0 || mem_din !== 8'h3E) begin
            tests_failed++;
            $display("FAIL seg1_latency: wr=%0b addr=%h bank=%0d din=%h required 1/400005/0/3e", mem_wr, mem_addr, mem_bank, mem_din);
        end
        repeat (3) @(negedge clk_sys);
        tests_run++;
        if (mem_wr !== 1'b1 || mem_addr !== 23'h400005 || mem_din !== 8'h3E) begin
            tests_failed++;
            $display("FAIL seg1_hold: wr=%0b addr=%h din=%h required 1/400005/3e", mem_wr, mem_addr, mem_din);
        end
        ack_one("seg1_ack");
        tests_run++;
        if (mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL seg1_pop: mem_wr=%0b required 0", mem_wr);
        end
    endtask

    task automatic test_map();
        wr_byte(25'h1_C000, 8'hA5);
        tests_run++;
        if (mem_addr !== 23'h7FC000 || mem_bank !== 2'd1) begin
            tests_failed++;
            $display("FAIL seg7_map: addr=%h bank=%0d required 7fc000/1", mem_addr, mem_bank);
        end
        ack_one("seg7_ack");
        wr_byte(25'h2_0000, 8'h11);
        tests_run++;
        if (mem_wr !== 1'b0 || dropped !== 1'b1) begin
            tests_failed++;
            $display("FAIL seg8_drop: mem_wr=%0b dropped=%0b required 0/1", mem_wr, dropped);
        end
        wr_byte(25'h0_0012, 8'h01);
        wr_byte(25'h0_8034, 8'h02);
        wr_byte(25'h0_FFFF, 8'h03);
        wr_byte(25'h1_3FFF, 8'h04);
        for (int i = 0; i < 4; i++) ack_one("map_table");
    endtask

    task automatic test_ack_ignored();
        @(negedge clk_sys);
        mem_ack = 1'b1;
        @(negedge clk_sys);
        mem_ack = 1'b0;
        tests_run++;
        if (mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_ack: mem_wr=%0b required 0", mem_wr);
        end
        wr_byte(25'h0_0100, 8'h5A);
        ack_one("after_stray_ack");
        tests_run++;
        if (mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_ack_empty: mem_wr=%0b required 0", mem_wr);
        end
    endtask

    task automatic test_overflow();
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_pre: overflow=%0b required 0", overflow);
        end
        for (int i = 0; i < 5; i++) wr_byte(25'h0_4000 + 25'(i), 8'h80 + 8'(i));
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_set: overflow=%0b required 1", overflow);
        end
        for (int i = 0; i < 4; i++) ack_one("overflow_order");
        tests_run++;
        if (mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_lost: mem_wr=%0b required 0 (fifth byte must be lost)", mem_wr);
        end
    endtask

    task automatic test_drain_done();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        tests_run++;
        if (cpu_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_cpu_reset: cpu_reset=%0b required 0", cpu_reset);
        end
        start_load();
        tests_run++;
        if (overflow !== 1'b0 || dropped !== 1'b0 || cpu_reset !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_clear: ovf=%0b drop=%0b cpu_reset=%0b required 0/0/1", overflow, dropped, cpu_reset);
        end
        wr_byte(25'h0_0200, 8'hC1);
        wr_byte(25'h0_4201, 8'hC2);
        wr_byte(25'h1_0202, 8'hC3);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        ack_one("drain_1");
        ack_one("drain_2");
        tests_run++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_hold: cpu_reset=%0b done=%0b required 1/0", cpu_reset, done);
        end
        ack_one("drain_3");
        tests_run++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%0b cpu_reset=%0b mem_wr=%0b required 1/0/0", done, cpu_reset, mem_wr);
        end
        @(negedge clk_sys);
        tests_run++;
        if (done !== 1'b0 || cpu_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_width: done=%0b cpu_reset=%0b required 0/0", done, cpu_reset);
        end
    endtask

    task automatic test_back_to_back();
        start_load();
        for (int i = 0; i < 4; i++) wr_byte(25'h0_C0A0 + 25'(i), 8'h60 + 8'(i));
        tests_run++;
        if (sb.size() == 0 || {mem_bank, mem_addr, mem_din} !== sb[0]) begin
            tests_failed++;
            $display("FAIL b2b_head: bank/addr/din=%h/%h/%h required head of %0d entries", mem_bank, mem_addr, mem_din, sb.size());
        end
        if (sb.size() != 0) void'(sb.pop_front());
        sb.push_back(exp_entry(25'h0_C0AA, 8'h77));
        ioctl_addr = 25'h0_C0AA;
        ioctl_dout = 8'h77;
        ioctl_wr   = 1'b1;
        mem_ack    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        mem_ack    = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_overflow: overflow=%0b required 0", overflow);
        end
        wr_byte(25'h0_C0BB, 8'h99);
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_still_full: overflow=%0b required 1", overflow);
        end
        for (int i = 0; i < 4; i++) ack_one("b2b_order");
        tests_run++;
        if (mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_empty: mem_wr=%0b required 0", mem_wr);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        wr_byte(25'h0_0300, 8'hD0);
        wr_byte(25'h0_0301, 8'hD1);
        @(negedge clk_sys);
        #2;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        #1;
        tests_run++;
        if (mem_wr !== 1'b0 || cpu_reset !== 1'b0 || mem_addr !== 23'h0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: wr=%0b cpu_reset=%0b addr=%h ovf=%0b required 0/0/0/0", mem_wr, cpu_reset, mem_addr, overflow);
        end
        sb.delete();
        @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (mem_wr !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_discard: mem_wr high in %0d cycles, required 0", bad);
        end
    endtask

    task automatic test_other_index();
        int bad = 0;
        @(negedge clk_sys);
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            ioctl_addr = 25'h0_0400 + 25'(i);
            ioctl_dout = 8'hE0 + 8'(i);
            ioctl_wr   = 1'b1;
            @(negedge clk_sys);
            ioctl_wr   = 1'b0;
            if (mem_wr !== 1'b0 || cpu_reset !== 1'b0) bad++;
        end
        @(negedge clk_sys);
        if (mem_wr !== 1'b0 || cpu_reset !== 1'b0) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL other_index: %0d cycles with mem_wr or cpu_reset high, required 0", bad);
        end
        ioctl_download = 1'b0;
        ioctl_index    = LOAD_INDEX;
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_ack        = 1'b0;

        test_reset();
        test_basic();
        test_map();
        test_ack_ignored();
        test_overflow();
        test_drain_done();
        test_back_to_back();
        test_reset_mid();
        test_other_index();

        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover: %0d entries never written, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
